// File: rtl/mem_stage_sram_ctrl_if.sv
// MEM-stage bus bundle: EXE/MEM pipeline inputs, WB-side outputs and the async SRAM pins.
// Handshake: the upstream instruction is held stable while ready=0 and advances on the
// first rising edge where ready=1; pass-through outputs are valid whenever ready=1.
interface mem_stage_sram_ctrl_if #(
  parameter int SRAM_AW = 18
);
  logic               wb_en_in;
  logic               mem_read_in;
  logic               mem_write_in;
  logic [31:0]        alu_res_in;
  logic [31:0]        val_rm_in;
  logic [3:0]         dst_in;
  logic               ready;
  logic               wb_en_out;
  logic               mem_read_out;
  logic [3:0]         dst_out;
  logic [31:0]        alu_res_out;
  logic [31:0]        mem_read_data;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_dq_o;
  logic [31:0]        sram_dq_i;
  logic               sram_we_n;
  logic               sram_oe_n;

  modport slave (
    input  wb_en_in, mem_read_in, mem_write_in, alu_res_in, val_rm_in, dst_in, sram_dq_i,
    output ready, wb_en_out, mem_read_out, dst_out, alu_res_out, mem_read_data,
    output sram_addr, sram_dq_o, sram_we_n, sram_oe_n
  );

  modport master (
    output wb_en_in, mem_read_in, mem_write_in, alu_res_in, val_rm_in, dst_in, sram_dq_i,
    input  ready, wb_en_out, mem_read_out, dst_out, alu_res_out, mem_read_data,
    input  sram_addr, sram_dq_o, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: turns loads/stores into multi-cycle async SRAM accesses, stalling via ready.
// Optional MEM_WRITE_POST_EN: stores are posted and drain in the background.
module mem_stage_sram_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 4,
  parameter int SRAM_AW     = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_sram_ctrl_if.slave  bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [SRAM_AW-1:0] addr_q;
  logic [31:0]        data_q;
  logic [31:0]        rdata_q;
  logic               is_write;
  logic               we_n_q;
  logic               oe_n_q;
  logic               req;
  logic               ready_c;
`ifdef MEM_WRITE_POST_EN
  logic               posted;
`endif

  assign req = bus.mem_read_in | bus.mem_write_in;

  assign bus.wb_en_out     = bus.wb_en_in;
  assign bus.mem_read_out  = bus.mem_read_in;
  assign bus.dst_out       = bus.dst_in;
  assign bus.alu_res_out   = bus.alu_res_in;
  assign bus.mem_read_data = rdata_q;
  assign bus.sram_addr     = addr_q;
  assign bus.sram_dq_o     = data_q;
  assign bus.sram_we_n     = we_n_q;
  assign bus.sram_oe_n     = oe_n_q;
  assign bus.ready         = ready_c;
  assign state_dbg         = state;

  always_comb begin
    ready_c = 1'b0;
    case (state)
`ifdef MEM_WRITE_POST_EN
      // A store with nothing in flight is accepted at once; only memory ops wait on a drain.
      IDLE:   ready_c = !req || bus.mem_write_in;
      ACCESS: ready_c = posted && !req;
`else
      IDLE:   ready_c = !req;
      ACCESS: ready_c = 1'b0;
`endif
      DONE:   ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      is_write <= 1'b0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
`ifdef MEM_WRITE_POST_EN
      posted   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // Low two address bits are dropped: the SRAM is word addressed.
            addr_q   <= SRAM_AW'((bus.alu_res_in - 32'(ADDR_BASE)) >> 2);
            data_q   <= bus.val_rm_in;
            is_write <= bus.mem_write_in;
            we_n_q   <= !bus.mem_write_in;
            oe_n_q   <= bus.mem_write_in;
            cnt      <= '0;
`ifdef MEM_WRITE_POST_EN
            posted   <= bus.mem_write_in;
`endif
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            we_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            if (!is_write) rdata_q <= bus.sram_dq_i;
`ifdef MEM_WRITE_POST_EN
            state  <= posted ? IDLE : DONE;
            posted <= 1'b0;
`else
            state  <= DONE;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed scenarios plus random load/store/ALU traffic
// checked against a cycle-budget and word-memory reference model.
module tb_mem_stage_sram_ctrl;

  localparam int BASE = 1024;
  localparam int W    = 4;
  localparam int AW   = 18;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         busy_end = -100;
  logic [31:0] last_load = '0;

  logic [31:0] sram_mem [0:(1<<AW)-1];
  logic [31:0] ref_mem [logic [AW-1:0]];

  mem_stage_sram_ctrl_if #(.SRAM_AW(AW)) bus ();

  mem_stage_sram_ctrl #(
    .ADDR_BASE(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .state_dbg(state_dbg)
  );

  // Clock / reset-independent infrastructure and the external SRAM device.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (!bus.sram_we_n) sram_mem[bus.sram_addr] <= bus.sram_dq_o;
  assign bus.sram_dq_i = sram_mem[bus.sram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 = non-memory op, 1 = load, 2 = store. Called just after a rising edge.
  task automatic do_op(input int kind, input logic [31:0] alu, input logic [31:0] val,
                       input logic [3:0] dst, input logic wb);
    int s, t, stall, exp_stall, we_cnt, oe_cnt;
    logic [AW-1:0] exp_addr, seen_addr;
    logic [31:0] exp_rd;
    bit seen, done;
    bus.wb_en_in     = wb;
    bus.mem_read_in  = (kind == 1);
    bus.mem_write_in = (kind == 2);
    bus.alu_res_in   = alu;
    bus.val_rm_in    = val;
    bus.dst_in       = dst;
    s = cyc;
    exp_addr = AW'((alu - 32'(BASE)) >> 2);
    exp_rd = ref_mem.exists(exp_addr) ? ref_mem[exp_addr] : 32'h0;
    // A memory op cannot start until any background write has drained.
    t = (kind != 0 && s <= busy_end) ? busy_end + 1 : s;
    if (kind == 0) exp_stall = 0;
`ifdef MEM_WRITE_POST_EN
    else if (kind == 2) exp_stall = t - s;
`endif
    else exp_stall = t - s + 1 + W;
    stall = 0; we_cnt = 0; oe_cnt = 0; seen = 0; done = 0; seen_addr = '0;
    for (int n = 0; n < 80 && !done; n++) begin
      @(negedge clk);
      if (!bus.sram_we_n) we_cnt++;
      if (!bus.sram_oe_n) oe_cnt++;
`ifdef MEM_WRITE_POST_EN
      if (!bus.sram_oe_n) begin seen = 1; seen_addr = bus.sram_addr; end
`else
      if (!bus.sram_oe_n || !bus.sram_we_n) begin seen = 1; seen_addr = bus.sram_addr; end
`endif
      if (bus.ready) done = 1;
      else begin
        stall++;
        @(posedge clk); #1;
      end
    end
    if (!done) check("ready_timeout", 32'(bus.ready), 32'd1);
    check("stall_cycles", 32'(stall), 32'(exp_stall));
    check("wb_en_out", 32'(bus.wb_en_out), 32'(wb));
    check("mem_read_out", 32'(bus.mem_read_out), 32'(kind == 1));
    check("dst_out", 32'(bus.dst_out), 32'(dst));
    check("alu_res_out", bus.alu_res_out, alu);
    if (kind == 1) begin
      check("load_data", bus.mem_read_data, exp_rd);
      check("oe_low_cycles", 32'(oe_cnt), 32'(W));
      last_load = exp_rd;
    end else begin
      check("load_data_held", bus.mem_read_data, last_load);
    end
    if (seen) check("sram_addr", 32'(seen_addr), 32'(exp_addr));
    if (kind == 0 && s > busy_end) check("no_strobe", 32'(we_cnt + oe_cnt), 32'd0);
    if (kind == 2) begin
`ifdef MEM_WRITE_POST_EN
      busy_end = t + W;
`else
      check("we_low_cycles", 32'(we_cnt), 32'(W));
      check("sram_dq_o", bus.sram_dq_o, val);
`endif
      ref_mem[exp_addr] = val;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 32'h0;
    rst = 1'b0;
    bus.wb_en_in = 0; bus.mem_read_in = 0; bus.mem_write_in = 0;
    bus.alu_res_in = 0; bus.val_rm_in = 0; bus.dst_in = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    check("rst_oe_n", 32'(bus.sram_oe_n), 32'd1);
    check("rst_rdata", bus.mem_read_data, 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_addr", 32'(bus.sram_addr), 32'd0);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("post_rst_ready", 32'(bus.ready), 32'd1);
    end

    // Directed store / load / ALU
    do_op(2, 32'd1028, 32'hDEADBEEF, 4'd1, 1'b0);
    do_op(1, 32'd1028, 32'h0, 4'd2, 1'b1);
    do_op(0, 32'd7, 32'h0, 4'd3, 1'b1);
    repeat (W + 2) do_op(0, 32'd7, 32'h0, 4'd3, 1'b1);

    // Store aborted by reset in its second ACCESS cycle
    bus.mem_write_in = 1; bus.mem_read_in = 0;
    bus.alu_res_in = 32'(BASE + 4 * 200); bus.val_rm_in = 32'hA5A5A5A5;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_abort_we_n", 32'(bus.sram_we_n), 32'd0);
    rst = 1'b0;
    bus.mem_write_in = 0;
    #1;
    check("abort_we_n", 32'(bus.sram_we_n), 32'd1);
    check("abort_oe_n", 32'(bus.sram_oe_n), 32'd1);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_addr", 32'(bus.sram_addr), 32'd0);
    check("abort_dq_o", bus.sram_dq_o, 32'h0);
    check("abort_rdata", bus.mem_read_data, 32'h0);
    last_load = '0;
    busy_end = -100;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_release_ready", 32'(bus.ready), 32'd1);

    // Store immediately followed by load of the same word
    do_op(2, 32'd1032, 32'h00000055, 4'd4, 1'b0);
    do_op(1, 32'd1032, 32'h0, 4'd5, 1'b1);

    // Address below the base wraps to the top SRAM word; low bits ignored
    do_op(2, 32'd1020, 32'h13572468, 4'd6, 1'b0);
    do_op(1, 32'd1023, 32'h0, 4'd7, 1'b1);
    do_op(1, 32'd1029, 32'h0, 4'd8, 1'b1);
    do_op(1, 32'd1300, 32'h0, 4'd9, 1'b1);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 2);
      if (k == 0)
        do_op(0, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else
        do_op(k, 32'(BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3)), $urandom,
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    repeat (W + 2) do_op(0, 32'd1, 32'h0, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
